hvgen_param: RTL and testbench
==============================

Name: hvgen_param

Overview:
- Parametrised successor to the fixed 256/240-wide video timing generator used by the System 1 core.
- Produces H/V counters, blanking, sync, line and frame strobes, and a registered RGB pass-through with optional blank-zeroing.
- All geometry comes from parameters. Sync position is adjustable per frame from signed offsets, clamped so sync never overlaps active video.
- Sits between the video mixer (which consumes HPOS/VPOS) and the scan-doubler/HDMI path (which consumes oRGB, blanking and sync).

Parameters:
RGB_W, 15, colour bus width
H_TOTAL, 384, pixels per line (counter 0..H_TOTAL-1)
H_ACT_BEG, 30, first active pixel, wide mode
H_ACT_END, 286, first blank pixel, wide mode
H_NARROW, 8, pixels trimmed from each side in narrow mode
H_SYNC_BEG, 304, nominal HSYNC start
H_SYNC_LEN, 32, HSYNC width in pixels
H_OFS_STEP, 2, pixels per HOFFS unit
HPOS_OFS, 16, HPOS = hcnt - HPOS_OFS (9-bit wrap)
V_TOTAL, 264, lines per frame
V_ACT, 224, active lines 0..V_ACT-1
V_SYNC_BEG, 234, nominal VSYNC start line
V_SYNC_LEN, 4, VSYNC width in lines
V_OFS_STEP, 4, lines per VOFFS unit
SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
BLANK_ZERO, 1, 1 = oRGB forced to 0 while HBLK or VBLK

Ports:
CLK  in  1  system clock
RESET  in  1  reset
PCLK_EN  in  1  pixel-clock enable; all state advances only when high
iRGB  in  RGB_W  pixel colour from mixer
H240  in  1  1 = narrow active window
HOFFS  in  5  signed HSYNC offset in H_OFS_STEP units
VOFFS  in  4  signed VSYNC offset in V_OFS_STEP units
HPOS  out  9  hcnt - HPOS_OFS
VPOS  out  9  vcnt
oRGB  out  RGB_W  registered colour
HBLK, VBLK, HSYN, VSYN  out  1 each  blanking and sync
LSTART  out  1  high for the enable where hcnt==0
FSTART  out  1  high for the enable where hcnt==0 and vcnt==0

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RESET.
- RESET is honoured regardless of PCLK_EN. Reset values:
  - hcnt = 0, vcnt = 0.
  - HBLK = 1, VBLK = 0, oRGB = 0, LSTART = 0, FSTART = 0.
  - HSYN and VSYN at their inactive level (= ~SYNC_POL).
  - Latched offsets = 0.
- Counters:
  - hcnt increments each enable and wraps at H_TOTAL-1 to 0.
  - On that wrap, vcnt increments and wraps at V_TOTAL-1 to 0.
  - No other jumps.
- Output alignment: all timing outputs are registers decoded from the next counter values, so they are aligned with HPOS/VPOS in the same cycle.
- Horizontal blanking:
  - Active window is [H_ACT_BEG, H_ACT_END) in wide mode.
  - In narrow mode it is [H_ACT_BEG+H_NARROW, H_ACT_END-H_NARROW).
  - HBLK = 1 outside the window.
- Vertical blanking: VBLK = 1 for vcnt >= V_ACT.
- Offsets:
  - HOFFS and VOFFS are sampled only at frame end (hcnt==H_TOTAL-1 and vcnt==V_TOTAL-1).
  - Mid-frame changes take effect from the next frame.
  - H240 is sampled at line end.
- Sync positions:
  - hs_beg = H_SYNC_BEG + HOFFS*H_OFS_STEP, computed signed at 11 bits, then clamped to [H_ACT_END, H_TOTAL-H_SYNC_LEN].
  - vs_beg is computed the same way, clamped to [V_ACT, V_TOTAL-V_SYNC_LEN].
- Sync outputs:
  - HSYN is active for hcnt in [hs_beg, hs_beg+H_SYNC_LEN).
  - VSYN is active for the whole of lines [vs_beg, vs_beg+V_SYNC_LEN), asserted from hcnt==0 of the first line.
- RGB path:
  - oRGB is iRGB registered on the enable, giving a latency of one enable.
  - If BLANK_ZERO is set, oRGB = 0 when the blanking that applied to the sampled pixel was high.
- Enable gating: with PCLK_EN low, every output holds its value.

Test Plan:
- Reset, then 384 enables, wide mode:
  - HBLK falls at hcnt 30 and rises at 286; HPOS = 14 at hcnt 30.
  - HSYN low for hcnt 304..335; LSTART high only at hcnt 0.
- H240 = 1 → HBLK falls at 38 and rises at 278. Toggling H240 mid-line changes the window only from the next line.
- HOFFS = +3 → HSYN low at 310..341. HOFFS = -15 → clamped, HSYN low at 286..317.
- Frame sequencing, default offsets:
  - Full frame: VBLK high at lines 224..263.
  - VSYN low at lines 234..237; FSTART once per 101376 enables.
  - VOFFS = +7 → clamped to 260..263.
- Mid-frame offset write: VOFFS set to -2 at line 100 → current frame keeps VSYN at 234; next frame VSYN at 226..229.
- Enable gating and reset: PCLK_EN toggled 1/0 randomly → outputs frozen on idle cycles.
  - RESET asserted at hcnt 200, vcnt 150 with PCLK_EN low → next cycle hcnt = 0, vcnt = 0, all outputs at reset values.
- RGB path: iRGB = 0x7FFF continuous → oRGB = 0x7FFF one enable after each active pixel, and 0 during blanking (BLANK_ZERO = 1).

Source files
------------

// File: rtl/hvgen_param_if.sv
`timescale 1ns/1ps
// Video timing generator bus: mixer-side inputs plus timing and colour outputs.
interface hvgen_param_if #(
    parameter int RGB_W = 15
);
    logic             PCLK_EN;
    logic [RGB_W-1:0] iRGB;
    logic             H240;
    logic [4:0]       HOFFS;
    logic [3:0]       VOFFS;
    logic [8:0]       HPOS;
    logic [8:0]       VPOS;
    logic [RGB_W-1:0] oRGB;
    logic             HBLK;
    logic             VBLK;
    logic             HSYN;
    logic             VSYN;
    logic             LSTART;
    logic             FSTART;

    modport master (
        output PCLK_EN, iRGB, H240, HOFFS, VOFFS,
        input  HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LSTART, FSTART
    );

    modport slave (
        input  PCLK_EN, iRGB, H240, HOFFS, VOFFS,
        output HPOS, VPOS, oRGB, HBLK, VBLK, HSYN, VSYN, LSTART, FSTART
    );
endinterface

// File: rtl/hvgen_param.sv
`timescale 1ns/1ps
// Parametrised H/V video timing generator with per-frame sync offsets and registered RGB pass-through.
module hvgen_param #(
    parameter int RGB_W      = 15,
    parameter int H_TOTAL    = 384,
    parameter int H_ACT_BEG  = 30,
    parameter int H_ACT_END  = 286,
    parameter int H_NARROW   = 8,
    parameter int H_SYNC_BEG = 304,
    parameter int H_SYNC_LEN = 32,
    parameter int H_OFS_STEP = 2,
    parameter int HPOS_OFS   = 16,
    parameter int V_TOTAL    = 264,
    parameter int V_ACT      = 224,
    parameter int V_SYNC_BEG = 234,
    parameter int V_SYNC_LEN = 4,
    parameter int V_OFS_STEP = 4,
    parameter int SYNC_POL   = 0,
    parameter int BLANK_ZERO = 1
) (
    input  logic         CLK,
    input  logic         RESET,
    hvgen_param_if.slave vid
);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic POL   = 1'(SYNC_POL);
    localparam logic BZERO = (BLANK_ZERO != 0);

    localparam logic signed [10:0] H_BEG_W = 11'(H_ACT_BEG);
    localparam logic signed [10:0] H_END_W = 11'(H_ACT_END);
    localparam logic signed [10:0] H_BEG_N = 11'(H_ACT_BEG + H_NARROW);
    localparam logic signed [10:0] H_END_N = 11'(H_ACT_END - H_NARROW);
    localparam logic signed [10:0] HS_NOM  = 11'(H_SYNC_BEG);
    localparam logic signed [10:0] HS_LEN  = 11'(H_SYNC_LEN);
    localparam logic signed [10:0] HS_STEP = 11'(H_OFS_STEP);
    localparam logic signed [10:0] HS_MIN  = 11'(H_ACT_END);
    localparam logic signed [10:0] HS_MAX  = 11'(H_TOTAL - H_SYNC_LEN);
    localparam logic signed [10:0] V_ACT_L = 11'(V_ACT);
    localparam logic signed [10:0] VS_NOM  = 11'(V_SYNC_BEG);
    localparam logic signed [10:0] VS_LEN  = 11'(V_SYNC_LEN);
    localparam logic signed [10:0] VS_STEP = 11'(V_OFS_STEP);
    localparam logic signed [10:0] VS_MAX  = 11'(V_TOTAL - V_SYNC_LEN);

    function automatic logic signed [10:0] clamp11(input logic signed [10:0] val,
                                                   input logic signed [10:0] lo,
                                                   input logic signed [10:0] hi);
        if (val < lo) return lo;
        if (val > hi) return hi;
        return val;
    endfunction

    logic [HW-1:0]      hcnt, hcnt_n;
    logic [VW-1:0]      vcnt, vcnt_n;
    logic               narrow, narrow_n;
    logic [4:0]         hofs, hofs_n;
    logic [3:0]         vofs, vofs_n;
    logic               line_end, frame_end;
    logic signed [10:0] hofs_x, vofs_x, hs_beg, vs_beg;
    logic signed [10:0] hc, vc, act_beg, act_end;
    logic               hblk_n, vblk_n, hsyn_on, vsyn_on;

    // Every timing output is decoded from the post-increment position, using the
    // window/offsets that will be in force there, so outputs line up with HPOS/VPOS.
    always_comb begin
        line_end  = (hcnt == HW'(H_TOTAL - 1));
        frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));
        hcnt_n    = line_end ? '0 : hcnt + HW'(1);
        vcnt_n    = vcnt;
        if (line_end) vcnt_n = frame_end ? '0 : vcnt + VW'(1);
        narrow_n  = line_end  ? vid.H240  : narrow;
        hofs_n    = frame_end ? vid.HOFFS : hofs;
        vofs_n    = frame_end ? vid.VOFFS : vofs;

        hofs_x = {{6{hofs_n[4]}}, hofs_n};
        vofs_x = {{7{vofs_n[3]}}, vofs_n};
        hs_beg = clamp11(HS_NOM + hofs_x * HS_STEP, HS_MIN, HS_MAX);
        vs_beg = clamp11(VS_NOM + vofs_x * VS_STEP, V_ACT_L, VS_MAX);

        hc      = 11'(hcnt_n);
        vc      = 11'(vcnt_n);
        act_beg = narrow_n ? H_BEG_N : H_BEG_W;
        act_end = narrow_n ? H_END_N : H_END_W;
        hblk_n  = !((hc >= act_beg) && (hc < act_end));
        vblk_n  = (vc >= V_ACT_L);
        hsyn_on = (hc >= hs_beg) && (hc < hs_beg + HS_LEN);
        vsyn_on = (vc >= vs_beg) && (vc < vs_beg + VS_LEN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            hcnt       <= '0;
            vcnt       <= '0;
            narrow     <= 1'b0;
            hofs       <= '0;
            vofs       <= '0;
            vid.HBLK   <= 1'b1;
            vid.VBLK   <= 1'b0;
            vid.HSYN   <= ~POL;
            vid.VSYN   <= ~POL;
            vid.LSTART <= 1'b0;
            vid.FSTART <= 1'b0;
            vid.oRGB   <= '0;
        end else if (vid.PCLK_EN) begin
            hcnt       <= hcnt_n;
            vcnt       <= vcnt_n;
            narrow     <= narrow_n;
            hofs       <= hofs_n;
            vofs       <= vofs_n;
            vid.HBLK   <= hblk_n;
            vid.VBLK   <= vblk_n;
            vid.HSYN   <= hsyn_on ? POL : ~POL;
            vid.VSYN   <= vsyn_on ? POL : ~POL;
            vid.LSTART <= (hcnt_n == '0);
            vid.FSTART <= (hcnt_n == '0) && (vcnt_n == '0);
            // Current HBLK/VBLK belong to the pixel being sampled now.
            vid.oRGB   <= (BZERO && (vid.HBLK || vid.VBLK)) ? '0 : vid.iRGB;
        end
    end

    assign vid.HPOS = 9'(hcnt) - 9'(HPOS_OFS);
    assign vid.VPOS = 9'(vcnt);
endmodule

// File: tb/tb_hvgen_param.sv
`timescale 1ns/1ps
// Bench for hvgen_param: random pixels, enables and offsets checked against a pixel-position model.
module tb_hvgen_param;
    localparam int RGB_W      = 15;
    localparam int H_TOTAL    = 384;
    localparam int H_ACT_BEG  = 30;
    localparam int H_ACT_END  = 286;
    localparam int H_NARROW   = 8;
    localparam int H_SYNC_BEG = 304;
    localparam int H_SYNC_LEN = 32;
    localparam int H_OFS_STEP = 2;
    localparam int HPOS_OFS   = 16;
    localparam int V_TOTAL    = 16;
    localparam int V_ACT      = 8;
    localparam int V_SYNC_BEG = 11;
    localparam int V_SYNC_LEN = 2;
    localparam int V_OFS_STEP = 2;
    localparam int SYNC_POL   = 0;
    localparam int BLANK_ZERO = 1;
    localparam int FRAME      = H_TOTAL * V_TOTAL;
    localparam logic POL      = 1'(SYNC_POL);

    logic CLK = 1'b0;
    logic RESET = 1'b0;

    hvgen_param_if #(.RGB_W(RGB_W)) vid ();

    hvgen_param #(
        .RGB_W(RGB_W), .H_TOTAL(H_TOTAL), .H_ACT_BEG(H_ACT_BEG), .H_ACT_END(H_ACT_END),
        .H_NARROW(H_NARROW), .H_SYNC_BEG(H_SYNC_BEG), .H_SYNC_LEN(H_SYNC_LEN),
        .H_OFS_STEP(H_OFS_STEP), .HPOS_OFS(HPOS_OFS), .V_TOTAL(V_TOTAL), .V_ACT(V_ACT),
        .V_SYNC_BEG(V_SYNC_BEG), .V_SYNC_LEN(V_SYNC_LEN), .V_OFS_STEP(V_OFS_STEP),
        .SYNC_POL(SYNC_POL), .BLANK_ZERO(BLANK_ZERO)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .vid(vid)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Model: pixel position plus the window/offsets in force there.
    int h, v, mhofs, mvofs;
    logic fresh, mnarrow;
    logic [RGB_W-1:0] mrgb;
    // Stimulus values driven onto the bus.
    int hofs_i, vofs_i;
    logic h240;
    logic [RGB_W-1:0] irgb;

    function automatic int clampi(int x, int lo, int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    function automatic logic exp_hblk();
        int b, e;
        if (fresh) return 1'b1;
        b = H_ACT_BEG + (mnarrow ? H_NARROW : 0);
        e = H_ACT_END - (mnarrow ? H_NARROW : 0);
        return !(h >= b && h < e);
    endfunction

    function automatic logic exp_vblk();
        return !fresh && (v >= V_ACT);
    endfunction

    function automatic logic exp_hsyn();
        int b;
        b = clampi(H_SYNC_BEG + mhofs * H_OFS_STEP, H_ACT_END, H_TOTAL - H_SYNC_LEN);
        return (!fresh && h >= b && h < b + H_SYNC_LEN) ? POL : !POL;
    endfunction

    function automatic logic exp_vsyn();
        int b;
        b = clampi(V_SYNC_BEG + mvofs * V_OFS_STEP, V_ACT, V_TOTAL - V_SYNC_LEN);
        return (!fresh && v >= b && v < b + V_SYNC_LEN) ? POL : !POL;
    endfunction

    function automatic logic exp_lstart();
        return !fresh && (h == 0);
    endfunction

    function automatic logic exp_fstart();
        return !fresh && (h == 0) && (v == 0);
    endfunction

    function automatic logic [8:0] exp_hpos();
        return 9'(h - HPOS_OFS);
    endfunction

    task automatic drive(input logic en);
        vid.PCLK_EN = en;
        vid.iRGB    = irgb;
        vid.H240    = h240;
        vid.HOFFS   = 5'(hofs_i);
        vid.VOFFS   = 4'(vofs_i);
    endtask

    task automatic tick(input logic en);
        drive(en);
        @(posedge CLK);
        if (en) begin
            mrgb = ((BLANK_ZERO != 0) && (exp_hblk() || exp_vblk())) ? '0 : irgb;
            if (h == H_TOTAL - 1 && v == V_TOTAL - 1) begin
                mhofs = hofs_i;
                mvofs = vofs_i;
            end
            if (h == H_TOTAL - 1) begin
                mnarrow = h240;
                h = 0;
                v = (v == V_TOTAL - 1) ? 0 : v + 1;
            end else begin
                h = h + 1;
            end
            fresh = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset(input logic en);
        drive(en);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        h = 0; v = 0; fresh = 1'b1; mnarrow = 1'b0; mhofs = 0; mvofs = 0; mrgb = '0;
    endtask

    task automatic test_reset();
        irgb = '1; h240 = 1'b0; hofs_i = 0; vofs_i = 0;
        do_reset(1'b1);
        n_cmp++; if (vid.HBLK !== 1'b1) begin n_err++; $display("FAIL rst_hblk got %b want 1", vid.HBLK); end
        n_cmp++; if (vid.VBLK !== 1'b0) begin n_err++; $display("FAIL rst_vblk got %b want 0", vid.VBLK); end
        n_cmp++; if (vid.HSYN !== !POL) begin n_err++; $display("FAIL rst_hsyn got %b want %b", vid.HSYN, !POL); end
        n_cmp++; if (vid.VSYN !== !POL) begin n_err++; $display("FAIL rst_vsyn got %b want %b", vid.VSYN, !POL); end
        n_cmp++; if (vid.LSTART !== 1'b0) begin n_err++; $display("FAIL rst_lstart got %b want 0", vid.LSTART); end
        n_cmp++; if (vid.FSTART !== 1'b0) begin n_err++; $display("FAIL rst_fstart got %b want 0", vid.FSTART); end
        n_cmp++; if (vid.oRGB !== '0) begin n_err++; $display("FAIL rst_rgb got %h want 0", vid.oRGB); end
        n_cmp++; if (vid.HPOS !== 9'd496) begin n_err++; $display("FAIL rst_hpos got %0d want 496", vid.HPOS); end
        n_cmp++; if (vid.VPOS !== 9'd0) begin n_err++; $display("FAIL rst_vpos got %0d want 0", vid.VPOS); end
    endtask

    task automatic test_hline();
        for (int i = 0; i < H_TOTAL; i++) begin
            irgb = RGB_W'($urandom());
            tick(1'b1);
            n_cmp++; if (vid.HBLK !== exp_hblk()) begin n_err++; $display("FAIL hl_hblk h=%0d got %b want %b", h, vid.HBLK, exp_hblk()); end
            n_cmp++; if (vid.HPOS !== exp_hpos()) begin n_err++; $display("FAIL hl_hpos h=%0d got %0d want %0d", h, vid.HPOS, exp_hpos()); end
            n_cmp++; if (vid.LSTART !== exp_lstart()) begin n_err++; $display("FAIL hl_lstart h=%0d got %b want %b", h, vid.LSTART, exp_lstart()); end
            n_cmp++; if (vid.HSYN !== exp_hsyn()) begin n_err++; $display("FAIL hl_hsyn h=%0d got %b want %b", h, vid.HSYN, exp_hsyn()); end
            n_cmp++; if (vid.oRGB !== mrgb) begin n_err++; $display("FAIL hl_rgb h=%0d got %h want %h", h, vid.oRGB, mrgb); end
        end
    endtask

    task automatic test_narrow();
        for (int i = 0; i < 3 * H_TOTAL; i++) begin
            if (i == 100) h240 = 1'b1;
            if (i == H_TOTAL + 200) h240 = 1'b0;
            irgb = RGB_W'($urandom());
            tick(1'b1);
            n_cmp++; if (vid.HBLK !== exp_hblk()) begin n_err++; $display("FAIL nar_hblk h=%0d v=%0d got %b want %b", h, v, vid.HBLK, exp_hblk()); end
            n_cmp++; if (vid.oRGB !== mrgb) begin n_err++; $display("FAIL nar_rgb h=%0d got %h want %h", h, vid.oRGB, mrgb); end
        end
    endtask

    task automatic test_rgb();
        irgb = 15'h7FFF;
        for (int i = 0; i < 2 * H_TOTAL; i++) begin
            tick(1'b1);
            n_cmp++; if (vid.oRGB !== mrgb) begin n_err++; $display("FAIL rgb h=%0d v=%0d got %h want %h", h, v, vid.oRGB, mrgb); end
        end
    endtask

    task automatic test_gating();
        for (int i = 0; i < 1500; i++) begin
            irgb = RGB_W'($urandom());
            if ($urandom_range(0, 199) == 0) h240 = ~h240;
            tick(1'($urandom_range(0, 1)));
            n_cmp++; if (vid.HBLK !== exp_hblk()) begin n_err++; $display("FAIL gate_hblk h=%0d got %b want %b", h, vid.HBLK, exp_hblk()); end
            n_cmp++; if (vid.VBLK !== exp_vblk()) begin n_err++; $display("FAIL gate_vblk v=%0d got %b want %b", v, vid.VBLK, exp_vblk()); end
            n_cmp++; if (vid.HPOS !== exp_hpos()) begin n_err++; $display("FAIL gate_hpos got %0d want %0d", vid.HPOS, exp_hpos()); end
            n_cmp++; if (vid.VPOS !== 9'(v)) begin n_err++; $display("FAIL gate_vpos got %0d want %0d", vid.VPOS, v); end
            n_cmp++; if (vid.HSYN !== exp_hsyn()) begin n_err++; $display("FAIL gate_hsyn h=%0d got %b want %b", h, vid.HSYN, exp_hsyn()); end
            n_cmp++; if (vid.LSTART !== exp_lstart()) begin n_err++; $display("FAIL gate_lstart h=%0d got %b want %b", h, vid.LSTART, exp_lstart()); end
            n_cmp++; if (vid.oRGB !== mrgb) begin n_err++; $display("FAIL gate_rgb h=%0d got %h want %h", h, vid.oRGB, mrgb); end
        end
    endtask

    task automatic test_frames();
        int sh[5];
        int sv[5];
        int chg, fcount, guard;
        sh = '{3, -15, 0, 0, 0};
        sv = '{0, 7, -1, 0, 0};
        for (int s = 3; s < 5; s++) begin
            sh[s] = int'($urandom_range(0, 31)) - 16;
            sv[s] = int'($urandom_range(0, 15)) - 8;
        end
        hofs_i = 0; vofs_i = 0;
        guard = 0;
        while (!(h == 0 && v == 0) && guard < FRAME) begin
            irgb = RGB_W'($urandom());
            tick(1'b1);
            guard++;
        end
        for (int f = 0; f < 6; f++) begin
            fcount = 0;
            h240 = 1'($urandom_range(0, 1));
            // Frame 2 writes its offsets at line 5, well inside the frame.
            chg = (f == 2) ? 5 * H_TOTAL : int'($urandom_range(1, FRAME - 2));
            for (int k = 0; k < FRAME; k++) begin
                if (f < 5 && k == chg) begin hofs_i = sh[f]; vofs_i = sv[f]; end
                irgb = RGB_W'($urandom());
                tick(1'b1);
                if (vid.FSTART === 1'b1) fcount++;
                n_cmp++; if (vid.HBLK !== exp_hblk()) begin n_err++; $display("FAIL fr_hblk h=%0d v=%0d got %b want %b", h, v, vid.HBLK, exp_hblk()); end
                n_cmp++; if (vid.VBLK !== exp_vblk()) begin n_err++; $display("FAIL fr_vblk h=%0d v=%0d got %b want %b", h, v, vid.VBLK, exp_vblk()); end
                n_cmp++; if (vid.HSYN !== exp_hsyn()) begin n_err++; $display("FAIL fr_hsyn h=%0d ofs=%0d got %b want %b", h, mhofs, vid.HSYN, exp_hsyn()); end
                n_cmp++; if (vid.VSYN !== exp_vsyn()) begin n_err++; $display("FAIL fr_vsyn h=%0d v=%0d ofs=%0d got %b want %b", h, v, mvofs, vid.VSYN, exp_vsyn()); end
                n_cmp++; if (vid.FSTART !== exp_fstart()) begin n_err++; $display("FAIL fr_fstart h=%0d v=%0d got %b want %b", h, v, vid.FSTART, exp_fstart()); end
                n_cmp++; if (vid.VPOS !== 9'(v)) begin n_err++; $display("FAIL fr_vpos got %0d want %0d", vid.VPOS, v); end
                n_cmp++; if (vid.oRGB !== mrgb) begin n_err++; $display("FAIL fr_rgb h=%0d v=%0d got %h want %h", h, v, vid.oRGB, mrgb); end
            end
            n_cmp++; if (fcount !== 1) begin n_err++; $display("FAIL fr_fstart_count frame=%0d got %0d want 1", f, fcount); end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!(h == 200 && v == 12) && guard < FRAME) begin
            irgb = RGB_W'($urandom());
            tick(1'b1);
            guard++;
        end
        n_cmp++; if (vid.VPOS !== 9'd12) begin n_err++; $display("FAIL rm_reach got vpos %0d want 12", vid.VPOS); end
        tick(1'b0);
        do_reset(1'b0);
        n_cmp++; if (vid.HPOS !== 9'd496) begin n_err++; $display("FAIL rm_hpos got %0d want 496", vid.HPOS); end
        n_cmp++; if (vid.VPOS !== 9'd0) begin n_err++; $display("FAIL rm_vpos got %0d want 0", vid.VPOS); end
        n_cmp++; if (vid.HBLK !== 1'b1) begin n_err++; $display("FAIL rm_hblk got %b want 1", vid.HBLK); end
        n_cmp++; if (vid.VBLK !== 1'b0) begin n_err++; $display("FAIL rm_vblk got %b want 0", vid.VBLK); end
        n_cmp++; if (vid.HSYN !== !POL) begin n_err++; $display("FAIL rm_hsyn got %b want %b", vid.HSYN, !POL); end
        n_cmp++; if (vid.VSYN !== !POL) begin n_err++; $display("FAIL rm_vsyn got %b want %b", vid.VSYN, !POL); end
        n_cmp++; if (vid.LSTART !== 1'b0) begin n_err++; $display("FAIL rm_lstart got %b want 0", vid.LSTART); end
        n_cmp++; if (vid.FSTART !== 1'b0) begin n_err++; $display("FAIL rm_fstart got %b want 0", vid.FSTART); end
        n_cmp++; if (vid.oRGB !== '0) begin n_err++; $display("FAIL rm_rgb got %h want 0", vid.oRGB); end
        // Offsets must have been cleared too: first frame after reset uses nominal sync.
        hofs_i = 7; vofs_i = 7;
        for (int i = 0; i < 2 * H_TOTAL; i++) begin
            tick(1'b1);
            n_cmp++; if (vid.HSYN !== exp_hsyn()) begin n_err++; $display("FAIL rm_hsyn_after h=%0d got %b want %b", h, vid.HSYN, exp_hsyn()); end
            n_cmp++; if (vid.HPOS !== exp_hpos()) begin n_err++; $display("FAIL rm_hpos_after got %0d want %0d", vid.HPOS, exp_hpos()); end
        end
    endtask

    initial begin
        hofs_i = 0; vofs_i = 0; h240 = 1'b0; irgb = '0;
        h = 0; v = 0; fresh = 1'b1; mnarrow = 1'b0; mhofs = 0; mvofs = 0; mrgb = '0;
        drive(1'b0);
        test_reset();
        test_hline();
        test_narrow();
        test_rgb();
        test_gating();
        test_frames();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
